// File: rtl/uop_gate_exerciser_if.sv
// Bundle between the AND-gate exerciser and its surroundings.
// Optional NAND readback (nz) is present when UOP_EXERCISER_NAND_EN is defined.
// master: the side that requests runs and hosts the gate under test.
// slave:  the exerciser itself.
`timescale 1ns/1ps
interface uop_gate_exerciser_if #(
  parameter int unsigned ERR_W = 4
);
  logic             start;
  logic             z;
`ifdef UOP_EXERCISER_NAND_EN
  logic             nz;
`endif
  logic             x;
  logic             y;
  logic [1:0]       vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;

`ifdef UOP_EXERCISER_NAND_EN
  modport master (output start, z, nz, input x, y, vec, busy, done, pass, err_count);
  modport slave  (input start, z, nz, output x, y, vec, busy, done, pass, err_count);
`else
  modport master (output start, z, input x, y, vec, busy, done, pass, err_count);
  modport slave  (input start, z, output x, y, vec, busy, done, pass, err_count);
`endif
endinterface

// File: rtl/uop_gate_exerciser.sv
// Sequential exerciser for a 2-input AND gate: walks vectors 00,01,10,11, waits
// SETTLE_CYCLES after each, samples z and counts mismatches (saturating).
// Define UOP_EXERCISER_NAND_EN to also check the gate's NAND output nz.
`timescale 1ns/1ps
module uop_gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input logic                 clk,
  input logic                 n_reset,
  uop_gate_exerciser_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = (SETTLE_CYCLES > 0) ? CntW'(SETTLE_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             exp_and;
  logic [1:0]       mism;
  logic [ERR_W:0]   err_sum;

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    exp_and = vec_q[1] & vec_q[0];
`ifdef UOP_EXERCISER_NAND_EN
    mism    = 2'(bus.z != exp_and) + 2'(bus.nz == exp_and);
`else
    mism    = 2'(bus.z != exp_and);
`endif
    // One spare bit catches overflow so the count can saturate at all-ones.
    err_sum = {1'b0, err_q} + (ERR_W+1)'(mism);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          vec_d   = 2'd0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = StSettle;
          cnt_d   = CntLoad;
        end else begin
          state_d = StSample;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSample: begin
        err_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        if (vec_q == 2'd3) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StDrive) || (state_d == StSettle) || (state_d == StSample);
    done_d = (state_d == StDone);
    // pass reflects the count including the final vector's result.
    if (state_d == StDone) begin
      pass_d = (err_d == '0);
    end
  end

  // State and output registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.x         = vec_q[1];
  assign bus.y         = vec_q[0];
  assign bus.vec       = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;

endmodule
